// File: rtl/rx_line_driver.sv
// Receive-side line assembler: takes bytes from a UART receiver over a four-phase
// ready/ack handshake, buffers them until a terminator, then exposes the line.
module rx_line_driver #(
  parameter int          DEPTH      = 16,
  parameter logic [7:0]  TERMINATOR = 8'h0D,
  parameter int          TIMEOUT    = 50000
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     RxReady,
  input  logic [7:0]               RxData,
  input  logic                     RxError,
  output logic                     RxAck,
  output logic                     LineValid,
  output logic [$clog2(DEPTH):0]   LineLength,
  input  logic                     LineDone,
  input  logic [$clog2(DEPTH)-1:0] RdAddr,
  output logic [7:0]               RdData,
  output logic                     Overflow,
  output logic [7:0]               ErrCount,
  output logic                     Timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RX_IDLE       = 2'd0,
    RX_ACK        = 2'd1,
    RX_STORE      = 2'd2,
    RX_LINE_READY = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   len_q, len_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            tout_q, tout_d;
  logic [CW-1:0]   count_q, count_d;
  logic            discard_q, discard_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic            hold_err_q, hold_err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      rd_data_q;
  logic            wr_en_s;
  logic [AW-1:0]   wr_addr_s;

  logic [7:0]      mem_q [DEPTH];

  // Next-state and handshake/line-assembly decisions.
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    valid_d     = valid_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    err_cnt_d   = err_cnt_q;
    tout_d      = 1'b0;
    count_d     = count_q;
    discard_d   = discard_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;
    timer_d     = timer_q;
    wr_en_s     = 1'b0;
    wr_addr_s   = count_q[AW-1:0];

    case (state_q)
      RX_IDLE: begin
        if (RxReady) begin
          hold_data_d = RxData;
          hold_err_d  = RxError;
          ack_d       = 1'b1;
          timer_d     = {TW{1'b0}};
          state_d     = RX_ACK;
        end else if (count_q != {CW{1'b0}}) begin
          // A stalled partial line is flushed rather than left to merge with later traffic.
          if (timer_q == TW'(TIMEOUT - 1)) begin
            count_d   = {CW{1'b0}};
            discard_d = 1'b0;
            tout_d    = 1'b1;
            timer_d   = {TW{1'b0}};
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end else begin
          timer_d = timer_q;
        end
      end

      RX_ACK: begin
        if (!RxReady) begin
          ack_d   = 1'b0;
          state_d = RX_STORE;
        end else begin
          ack_d = 1'b1;
        end
      end

      RX_STORE: begin
        state_d = RX_IDLE;
        if (hold_err_q) begin
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end else if (hold_data_q == TERMINATOR) begin
          if (discard_q) begin
            discard_d = 1'b0;
            count_d   = {CW{1'b0}};
          end else if (count_q == {CW{1'b0}}) begin
            count_d = count_q;
          end else begin
            valid_d = 1'b1;
            len_d   = count_q;
            state_d = RX_LINE_READY;
          end
        end else if (discard_q) begin
          discard_d = 1'b1;
        end else if (count_q == CW'(DEPTH)) begin
          // Keep count at DEPTH so the timer can still flush the discarded line.
          ovf_d     = 1'b1;
          discard_d = 1'b1;
        end else begin
          wr_en_s = 1'b1;
          count_d = count_q + CW'(1);
        end
      end

      RX_LINE_READY: begin
        if (LineDone) begin
          valid_d = 1'b0;
          count_d = {CW{1'b0}};
          state_d = RX_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= RX_IDLE;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      len_q       <= {CW{1'b0}};
      ovf_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      tout_q      <= 1'b0;
      count_q     <= {CW{1'b0}};
      discard_q   <= 1'b0;
      hold_data_q <= 8'd0;
      hold_err_q  <= 1'b0;
      timer_q     <= {TW{1'b0}};
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      err_cnt_q   <= err_cnt_d;
      tout_q      <= tout_d;
      count_q     <= count_d;
      discard_q   <= discard_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
      timer_q     <= timer_d;
    end
  end

  // Line buffer storage; contents are not reset.
  always_ff @(posedge Clock) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= hold_data_q;
    end
  end

  // Registered read port, independent of the handshake state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_data_q <= 8'd0;
    end else begin
      rd_data_q <= mem_q[RdAddr];
    end
  end

  assign RxAck      = ack_q;
  assign LineValid  = valid_q;
  assign LineLength = len_q;
  assign Overflow   = ovf_q;
  assign ErrCount   = err_cnt_q;
  assign Timeout    = tout_q;
  assign RdData     = rd_data_q;

endmodule

// File: tb/tb_rx_line_driver.sv
// Self-checking bench for rx_line_driver: table of byte vectors plus
// hand-written back-pressure, timeout and mid-handshake reset sequences.
module tb_rx_line_driver;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 100;

  logic       Clock;
  logic       Reset;
  logic       RxReady;
  logic [7:0] RxData;
  logic       RxError;
  logic       RxAck;
  logic       LineValid;
  logic [4:0] LineLength;
  logic       LineDone;
  logic [3:0] RdAddr;
  logic [7:0] RdData;
  logic       Overflow;
  logic [7:0] ErrCount;
  logic       Timeout;

  int checks;
  int errors;

  rx_line_driver #(
    .DEPTH      (DEPTH),
    .TERMINATOR (8'h0D),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .RxReady    (RxReady),
    .RxData     (RxData),
    .RxError    (RxError),
    .RxAck      (RxAck),
    .LineValid  (LineValid),
    .LineLength (LineLength),
    .LineDone   (LineDone),
    .RdAddr     (RdAddr),
    .RdData     (RdData),
    .Overflow   (Overflow),
    .ErrCount   (ErrCount),
    .Timeout    (Timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         rep;
    logic       exp_valid;
    logic [4:0] exp_len;
    logic [7:0] exp_errs;
    logic       exp_ovf;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_exp;
    logic       done;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Full four-phase handshake; returns at the negedge after the store cycle.
  task automatic send_byte(input logic [7:0] d, input logic e);
    int n;
    RxData  = d;
    RxError = e;
    RxReady = 1'b1;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!RxAck && n < 50);
    check("ack_rise", RxAck, 1'b1);
    RxReady = 1'b0;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (RxAck && n < 50);
    check("ack_fall", RxAck, 1'b0);
    @(negedge Clock);
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    RdAddr = a;
    @(negedge Clock);
    check(name, RdData, exp);
  endtask

  task automatic line_done();
    LineDone = 1'b1;
    @(negedge Clock);
    LineDone = 1'b0;
    check("done_clears_valid", LineValid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    Reset = 1'b1; RxReady = 1'b0; RxData = 8'h00; RxError = 1'b0;
    LineDone = 1'b0; RdAddr = 4'd0;

    //            data   err  rep vld len    errs    ovf   rd   addr   exp    done
    vecs[0]  = '{8'h48, 1'b0, 1,  1'b0, 5'd0,  8'd1,   1'b0, 1'b0, 4'd0,  8'h00, 1'b0};
    vecs[1]  = '{8'h49, 1'b0, 1,  1'b0, 5'd0,  8'd1,   1'b0, 1'b0, 4'd0,  8'h00, 1'b0};
    vecs[2]  = '{8'h0D, 1'b0, 1,  1'b1, 5'd2,  8'd1,   1'b0, 1'b1, 4'd0,  8'h48, 1'b0};
    vecs[3]  = '{8'h00, 1'b0, 0,  1'b1, 5'd2,  8'd1,   1'b0, 1'b1, 4'd1,  8'h49, 1'b1};
    vecs[4]  = '{8'h41, 1'b1, 1,  1'b0, 5'd0,  8'd1,   1'b0, 1'b0, 4'd0,  8'h00, 1'b0};
    vecs[5]  = '{8'h42, 1'b0, 1,  1'b0, 5'd0,  8'd1,   1'b0, 1'b0, 4'd0,  8'h00, 1'b0};
    vecs[6]  = '{8'h0D, 1'b0, 1,  1'b1, 5'd1,  8'd1,   1'b0, 1'b1, 4'd0,  8'h42, 1'b1};
    vecs[7]  = '{8'h0D, 1'b0, 1,  1'b0, 5'd0,  8'd1,   1'b0, 1'b0, 4'd0,  8'h00, 1'b0};
    vecs[8]  = '{8'h61, 1'b0, 16, 1'b0, 5'd0,  8'd1,   1'b0, 1'b0, 4'd0,  8'h00, 1'b0};
    vecs[9]  = '{8'h0D, 1'b0, 1,  1'b1, 5'd16, 8'd1,   1'b0, 1'b1, 4'd15, 8'h61, 1'b1};
    vecs[10] = '{8'h55, 1'b0, 17, 1'b0, 5'd0,  8'd1,   1'b1, 1'b0, 4'd0,  8'h00, 1'b0};
    vecs[11] = '{8'h0D, 1'b0, 1,  1'b0, 5'd0,  8'd1,   1'b1, 1'b0, 4'd0,  8'h00, 1'b0};
    vecs[12] = '{8'h31, 1'b0, 1,  1'b0, 5'd0,  8'd1,   1'b1, 1'b0, 4'd0,  8'h00, 1'b0};
    vecs[13] = '{8'h0D, 1'b0, 1,  1'b1, 5'd1,  8'd1,   1'b1, 1'b1, 4'd0,  8'h31, 1'b1};
    vecs[14] = '{8'h77, 1'b1, 300, 1'b0, 5'd0, 8'd255, 1'b1, 1'b0, 4'd0,  8'h00, 1'b0};
    // Entries 0..3 run before the framing-error byte, so their ErrCount is 0.
    for (int i = 0; i < 4; i++) vecs[i].exp_errs = 8'd0;

    repeat (3) @(negedge Clock);
    check("rst_ack", RxAck, 1'b0);
    check("rst_valid", LineValid, 1'b0);
    check("rst_len", LineLength, 5'd0);
    check("rst_ovf", Overflow, 1'b0);
    check("rst_errs", ErrCount, 8'd0);
    check("rst_tout", Timeout, 1'b0);
    check("rst_rddata", RdData, 8'd0);
    Reset = 1'b0;
    @(negedge Clock);

    for (int i = 0; i < 15; i++) begin
      for (int r = 0; r < vecs[i].rep; r++) send_byte(vecs[i].data, vecs[i].err);
      check($sformatf("v%0d_valid", i), LineValid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("v%0d_len", i), LineLength, vecs[i].exp_len);
      check($sformatf("v%0d_errs", i), ErrCount, vecs[i].exp_errs);
      check($sformatf("v%0d_ovf", i), Overflow, vecs[i].exp_ovf);
      if (vecs[i].rd_en) read_check($sformatf("v%0d_rd", i), vecs[i].rd_addr, vecs[i].rd_exp);
      if (vecs[i].done) line_done();
    end

    // Back-pressure: a pending byte must wait for the consumer.
    send_byte(8'h50, 1'b0);
    send_byte(8'h0D, 1'b0);
    check("bp_valid", LineValid, 1'b1);
    RxData = 8'h41; RxError = 1'b0; RxReady = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      check("bp_ack_low", RxAck, 1'b0);
    end
    LineDone = 1'b1;
    @(negedge Clock);
    LineDone = 1'b0;
    check("bp_valid_cleared", LineValid, 1'b0);
    n = 1;
    while (!RxAck && n < 2) begin
      @(negedge Clock);
      n++;
    end
    check("bp_ack_rise", RxAck, 1'b1);
    RxReady = 1'b0;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (RxAck && n < 50);
    check("bp_ack_fall", RxAck, 1'b0);
    @(negedge Clock);
    send_byte(8'h0D, 1'b0);
    check("bp_line_valid", LineValid, 1'b1);
    check("bp_line_len", LineLength, 5'd1);
    read_check("bp_rd0", 4'd0, 8'h41);
    line_done();

    // Idle timeout flushes a partial line.
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    n = 0;
    while (!Timeout && n < 300) begin
      @(negedge Clock);
      n++;
    end
    check("tout_pulse", Timeout, 1'b1);
    check("tout_delay", n, TIMEOUT);
    @(negedge Clock);
    check("tout_one_cycle", Timeout, 1'b0);
    send_byte(8'h0D, 1'b0);
    check("tout_no_line", LineValid, 1'b0);

    // Reset in the middle of a handshake.
    RxData = 8'h99; RxError = 1'b0; RxReady = 1'b1;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!RxAck && n < 50);
    check("mid_ack_high", RxAck, 1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    check("mid_rst_ack", RxAck, 1'b0);
    check("mid_rst_valid", LineValid, 1'b0);
    check("mid_rst_len", LineLength, 5'd0);
    check("mid_rst_ovf", Overflow, 1'b0);
    check("mid_rst_errs", ErrCount, 8'd0);
    check("mid_rst_tout", Timeout, 1'b0);
    check("mid_rst_rddata", RdData, 8'd0);
    Reset = 1'b0;
    RxReady = 1'b0;
    @(negedge Clock);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h0D, 1'b0);
    check("post_rst_valid", LineValid, 1'b1);
    check("post_rst_len", LineLength, 5'd1);
    read_check("post_rst_rd0", 4'd0, 8'h5A);
    line_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_line_driver.md
Name: rx_line_driver

Overview:
Receive-side companion to the UART transmit driver. It consumes bytes from the UART receiver using a four-phase ready/ack handshake and assembles them into a line buffer until a terminator byte arrives. It then presents the completed line to a consumer through a registered read port. The block also counts framing errors, detects overflow, and flushes a partial line after an inter-byte timeout.

Parameters:
DEPTH, 16, line buffer size in bytes; must be a power of 2, minimum 4.
TERMINATOR, 8'h0D, end-of-line byte; it is never stored.
TIMEOUT, 50000, number of idle Clock cycles after which a partial line is flushed.

Ports:
Clock  in  1  single system clock; all logic is on its rising edge.
Reset  in  1  synchronous, active-high reset.
RxReady  in  1  UART receiver holds a byte; stays high until it sees RxAck.
RxData  in  8  received byte; valid while RxReady=1.
RxError  in  1  framing error for the current byte; valid while RxReady=1.
RxAck  out  1  byte consumed; held high until RxReady falls.
LineValid  out  1  a complete line is held in the buffer.
LineLength  out  $clog2(DEPTH)+1  number of stored bytes; valid while LineValid=1.
LineDone  in  1  one-cycle pulse from the consumer that releases the buffer.
RdAddr  in  $clog2(DEPTH)  read address.
RdData  out  8  registered mem[RdAddr]; 1-cycle latency; readable at any time.
Overflow  out  1  sticky flag; cleared only by Reset.
ErrCount  out  8  saturating framing-error count; cleared only by Reset.
Timeout  out  1  one-cycle pulse when a partial line is flushed.

Behaviour:
- Reset values: RxAck=0, LineValid=0, LineLength=0, Overflow=0, ErrCount=0, Timeout=0, RdData=0, count=0, discard=0, idle timer=0, state=RX_IDLE. Buffer contents are don't-care.
- Reset mid-operation: all of the above values are applied at the next edge. RxAck drops in that cycle, even mid-handshake.
- Internal signals: count (0..DEPTH), discard flag, hold register (byte+error), idle timer.
- RX_IDLE:
  - If RxReady=1: latch RxData and RxError into the hold register, set RxAck<=1, go to RX_ACK.
  - Otherwise, if count>0, increment the idle timer.
  - When the timer reaches TIMEOUT-1: count<=0, discard<=0, Timeout pulses for 1 cycle, timer<=0.
  - The timer clears whenever a byte is latched.
- RX_ACK:
  - Hold RxAck=1 until RxReady=0 is sampled.
  - Then RxAck<=0, go to RX_STORE.
  - Minimum handshake is 3 cycles per byte.
- RX_STORE, taking the first matching priority (always exactly 1 cycle, then RX_IDLE unless a line completes):
  1. Error byte: ErrCount++, saturating at 255. Byte dropped; count unchanged.
  2. byte==TERMINATOR:
     - If discard=1: discard<=0, count<=0.
     - Else if count==0: ignored; no empty lines are produced.
     - Else: LineValid<=1, LineLength<=count, go to RX_LINE_READY.
  3. discard=1: byte dropped.
  4. count==DEPTH: Overflow<=1, discard<=1. The byte and the partial line are both dropped (count<=0 at the terminator).
  5. Otherwise: mem[count]<=byte, count++.
- RX_LINE_READY:
  - RxAck stays 0, which back-pressures the receiver (RxReady is ignored).
  - The idle timer is frozen.
  - On LineDone=1: LineValid<=0, count<=0, go to RX_IDLE. The next byte may be latched on the following cycle.
- LineDone outside RX_LINE_READY is ignored.
- Exactly DEPTH data bytes followed by the terminator is legal and produces LineLength=DEPTH. Overflow is triggered only by byte DEPTH+1.
- RdData updates every cycle from RdAddr, independent of state. Writes and reads never collide, because writes occur only in RX_STORE and the consumer reads only while LineValid=1.

Test Plan:
1. Basic line: send 0x48, 0x49, 0x0D with the handshake modelled (receiver drops RxReady 1 cycle after RxAck) -> RxAck seen 3 times; LineValid=1, LineLength=2; RdAddr=0 gives RdData=0x48 one cycle later; RdAddr=1 gives 0x49. LineDone -> LineValid=0 on the next cycle.
2. Back-pressure: while LineValid=1, present 0x41 with RxReady=1 for 20 cycles -> RxAck stays 0. Pulse LineDone -> RxAck rises within 2 cycles and 0x41 is stored at address 0.
3. Overflow (DEPTH=16): 17 bytes of 0x55, then 0x0D -> Overflow=1, no LineValid. Then 0x31, 0x0D -> LineValid=1, LineLength=1, mem[0]=0x31, Overflow still 1.
4. Framing error: 0x41 with RxError=1, then 0x42, 0x0D -> ErrCount=1, LineLength=1, mem[0]=0x42. 300 error bytes -> ErrCount=255.
5. Timeout (TIMEOUT=100): 0x41, 0x42, then idle -> Timeout pulses exactly 100 cycles after the second handshake completes. A following 0x0D produces no LineValid (count=0).
6. Reset mid-handshake: assert Reset while RxAck=1 -> RxAck=0 at the next edge, all outputs at reset values; a subsequent line "Z\r" gives LineLength=1.
